tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//   Shared timebase controller: one free-running prescaler turns clk into a base tick.
//   That tick is shared among NCH programmable timer channels (one-shot or periodic).
//   Channel expirations are serialized onto one valid/ready event port by a round-robin arbiter.
//   Sits between the board clock and display-scan, debounce and animation logic, replacing per-user dividers.
// PARAMETERS
//   NCH      4      number of timer channels (power of 2, >=2); CW = $clog2(NCH)
//   PRESCALE 50000  clk cycles per base tick (50 MHz -> 1 ms); >=2
//   PW       16     channel period width, in base ticks
// PORTS
//   clk          in   1    system clock; all logic on posedge
//   rst_n        in   1    asynchronous, active-low reset
//   cfg_valid    in   1    config request valid
//   cfg_ready    out  1    config request accepted when cfg_valid & cfg_ready
//   cfg_ch       in   CW   target channel
//   cfg_op       in   2    00 stop, 01 start one-shot, 10 start periodic, 11 reserved (ignored)
//   cfg_period   in   PW   period in base ticks; 0 treated as 1
//   evt_valid    out  1    expiration event available
//   evt_ready    in   1    consumer accepts event
//   evt_ch       out  CW   channel that expired
//   evt_overrun  out  1    >=1 expiration of evt_ch was lost before this event
//   busy         out  NCH  busy[i]=1 while channel i is RUN
//   base_tick    out  1    one-clk pulse per prescaler period
// BEHAVIOUR
//   Reset (async, rst_n=0): prescaler cnt=0, all channels IDLE, pend/ovr=0, rr pointer=0.
//     Outputs in reset: cfg_ready=1; evt_valid=0; evt_ch=0; evt_overrun=0; busy=0; base_tick=0.
//     Reset mid-operation discards all state, including an event held in the output slot.
//   Prescaler: cnt counts 0..PRESCALE-1, then wraps to 0. base_tick=1 exactly when cnt==PRESCALE-1.
//     Free-running; never gated by config activity. First pulse is in the PRESCALE-th clk after reset release.
//   Config handshake: cfg_ready is registered and drops for the one clk following each accept.
//     Result: at most 1 accept per 2 clks. Reserved op 11 is accepted but has no effect.
//   Channel FSM (per channel): IDLE, RUN. Per-channel registers: rem[PW-1:0], mode, pend, ovr.
//     start (01/10), any state: rem <= max(cfg_period,1); mode <= op; state <= RUN.
//       Restarting a RUN channel reloads rem. pend and ovr are kept.
//       A base_tick in the accept cycle is not counted.
//     stop (00): state <= IDLE; pend <= 0; ovr <= 0.
//       An event already in the output slot is unaffected.
//     RUN & base_tick & rem>1: rem <= rem-1.
//     RUN & base_tick & rem==1: expire.
//       Periodic: rem reloads the stored period and the channel stays RUN.
//       One-shot: state <= IDLE.
//     Expire with pend=0 sets pend. Expire with pend=1 sets sticky ovr.
//     First expiry is on the period-th base_tick after accept.
//   Arbiter / output slot: slot = {evt_valid, evt_ch, evt_overrun}, registered.
//     The slot loads when evt_valid=0, or on a transfer (evt_valid & evt_ready).
//     Round-robin pick among pend bits, starting at the rr pointer. On pick:
//       load ch and its ovr into the slot; clear that pend and ovr; rr <= ch+1 (mod NCH).
//     If no pend bit is set on a load, evt_valid <= 0.
//     Slot contents are stable while evt_valid & !evt_ready.
//     Latency: base_tick in clk t -> pend visible in t+1 -> evt_valid in t+2 (slot empty). Full throughput: 1 event/clk.
//   Simultaneous events on one channel, same clk:
//     expire + pick: pend stays 1, ovr stays 0.
//     stop + expire: stop wins.
//     start + expire: start wins, no event is generated.
//   Widths: rem and period are unsigned PW bits. No wrap below 1.
// STRUCTURE
//   Package tick_sched_pkg holds the shared definitions:
//     OP_STOP/OP_ONESHOT/OP_PERIODIC/OP_RSVD localparams;
//     ch_state_t enum {CH_IDLE, CH_RUN}.
//   Sub-module tick_channel: FSM, rem, mode, pend, ovr. Instantiated NCH times via generate.
//   Prescaler, config decode and arbiter/output slot live in tick_scheduler.
// TESTING (sim with PRESCALE=4, NCH=4, PW=16)
//   1. Reset: pulse rst_n low mid-run with an event held.
//      Expect: all outputs 0 and cfg_ready=1 immediately; after release, base_tick every 4 clks, first at clk 4.
//   2. One-shot ch1, period 3, evt_ready=1.
//      Expect: evt_valid with evt_ch=1, evt_overrun=0, 2 clks after the 3rd base_tick.
//      busy[1] falls after that tick; no further events from ch1.
//   3. Periodic ch0, period 2, evt_ready=0 for 6 base ticks, then 1.
//      Expect: slot holds ch0/ovr=0 stable; then ch0 with evt_overrun=1; then nothing until the next expiry.
//   4. Periodic ch0..ch3, period 1, evt_ready=1.
//      Expect: per base tick, events delivered in order 0,1,2,3 on consecutive clks; no overrun.
//   5. Stop ch2 while its pend=1 but not in the slot.
//      Expect: no ch2 event, busy[2]=0. cfg_op=11 is accepted (cfg_ready low next clk) with no state change.
//   6. Start ch3 with period 0, and restart ch3 with period 5 mid-count.
//      Expect: period 0 expires on the 1st base tick; the restart expires 5 ticks after the restart accept.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: config opcodes and channel states.
package tick_sched_pkg;

  localparam logic [1:0] OP_STOP     = 2'b00;
  localparam logic [1:0] OP_ONESHOT  = 2'b01;
  localparam logic [1:0] OP_PERIODIC = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/tick_scheduler_if.sv
// Config request and expiration event handshakes of the tick scheduler.
interface tick_scheduler_if #(
  parameter int NCH = 4,
  parameter int PW  = 16
) ();
  localparam int CW = $clog2(NCH);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_op;
  logic [PW-1:0] cfg_period;

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic          evt_overrun;

  modport master (
    output cfg_valid, cfg_ch, cfg_op, cfg_period, evt_ready,
    input  cfg_ready, evt_valid, evt_ch, evt_overrun
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_op, cfg_period, evt_ready,
    output cfg_ready, evt_valid, evt_ch, evt_overrun
  );
endinterface

// File: rtl/tick_scheduler_channel.sv
// One programmable timer channel: down-counts base ticks and flags expirations.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          base_tick,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [PW-1:0] period,
  input  logic          pick,
  output logic          busy,
  output logic          pend,
  output logic          ovr
);

  ch_state_t     state_q, state_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [PW-1:0] reload_q, reload_d;
  logic          periodic_q, periodic_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          expire;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    pend_d     = pend_q;
    ovr_d      = ovr_q;
    expire     = 1'b0;

    // Config outranks counting, so a tick in the accept cycle is dropped.
    if (stop) begin
      state_d = CH_IDLE;
    end else if (start) begin
      reload_d   = (period == '0) ? PW'(1) : period;
      rem_d      = reload_d;
      periodic_d = periodic;
      state_d    = CH_RUN;
    end else if (state_q == CH_RUN && base_tick) begin
      if (rem_q > PW'(1)) begin
        rem_d = rem_q - PW'(1);
      end else begin
        expire = 1'b1;
        if (periodic_q) begin
          rem_d = reload_q;
        end else begin
          state_d = CH_IDLE;
        end
      end
    end

    if (pick) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
    // An expiry landing on the pick cycle just re-arms pend.
    if (expire) begin
      if (pend_q && !pick) begin
        ovr_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
    if (stop) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CH_IDLE;
      rem_q      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy = (state_q == CH_RUN);
  assign pend = pend_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler, config decode and round-robin event slot over NCH timer channels.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 50000,
  parameter int PW       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tick_scheduler_if.slave  bus,
  output logic [NCH-1:0]   busy,
  output logic             base_tick
);

  localparam int CW = $clog2(NCH);
  localparam int SW = $clog2(PRESCALE);

  logic [SW-1:0]  cnt_q, cnt_d;
  logic           cfg_ready_q, cfg_ready_d;
  logic           accept;
  logic           op_start, op_stop, op_periodic;
  logic [NCH-1:0] pend, ovr, pick;
  logic [CW-1:0]  rr_q, rr_d;
  logic           evt_valid_q, evt_valid_d;
  logic [CW-1:0]  evt_ch_q, evt_ch_d;
  logic           evt_ovr_q, evt_ovr_d;
  logic           slot_load;
  logic           found;
  logic [CW-1:0]  pick_idx;

  assign base_tick = (cnt_q == SW'(PRESCALE - 1));
  assign cnt_d     = base_tick ? '0 : cnt_q + SW'(1);

  // Registered ready forces an idle cycle after every accept.
  assign accept      = bus.cfg_valid & cfg_ready_q;
  assign cfg_ready_d = ~accept;

  always_comb begin
    op_start    = 1'b0;
    op_stop     = 1'b0;
    op_periodic = 1'b0;
    case (bus.cfg_op)
      OP_STOP:     op_stop = 1'b1;
      OP_ONESHOT:  op_start = 1'b1;
      OP_PERIODIC: begin
        op_start    = 1'b1;
        op_periodic = 1'b1;
      end
      OP_RSVD:     ;
      default:     ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic sel;
      assign sel     = accept && (bus.cfg_ch == CW'(gi));
      assign pick[gi] = slot_load && found && (pick_idx == CW'(gi));

      tick_channel #(.PW(PW)) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_tick (base_tick),
        .start     (sel && op_start),
        .stop      (sel && op_stop),
        .periodic  (op_periodic),
        .period    (bus.cfg_period),
        .pick      (pick[gi]),
        .busy      (busy[gi]),
        .pend      (pend[gi]),
        .ovr       (ovr[gi])
      );
    end
  endgenerate

  // First pending channel at or after the rr pointer, wrapping mod NCH.
  always_comb begin
    logic [CW-1:0] idx;
    found    = 1'b0;
    pick_idx = rr_q;
    idx      = rr_q;
    for (int k = 0; k < NCH; k++) begin
      idx = rr_q + CW'(k);
      if (!found && pend[idx]) begin
        found    = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign slot_load = !evt_valid_q || bus.evt_ready;

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_ovr_d   = evt_ovr_q;
    rr_d        = rr_q;
    if (slot_load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d  = pick_idx;
        evt_ovr_d = ovr[pick_idx];
        rr_d      = pick_idx + CW'(1);
      end else begin
        evt_ovr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cfg_ready_q <= 1'b1;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_ovr_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_ovr_q   <= evt_ovr_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_ch      = evt_ch_q;
  assign bus.evt_overrun = evt_ovr_q;

endmodule
